fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ADD_WIDTH, default 5, giving the instruction address width in bits.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port PC_cur, input, ADD_WIDTH bits: current program-counter value.
REQ-005 The block SHALL have port Imem_ack, input, 1 bit: instruction memory returns data this cycle; valid only while Imem_req=1.
REQ-006 The block SHALL have port Imem_rdata, input, 32 bits: instruction word, valid when Imem_ack=1.
REQ-007 The block SHALL have port Id_ready, input, 1 bit: decode stage can accept an instruction.
REQ-008 The block SHALL have port Hz_stall, input, 1 bit: load-use hazard; blocks hand-off to decode.
REQ-009 The block SHALL have port Redirect, input, 1 bit: taken branch/jump resolved this cycle.
REQ-010 The block SHALL have port Redirect_add, input, ADD_WIDTH bits: redirect target, valid with Redirect.
REQ-011 The block SHALL have port Imem_req, output, 1 bit: fetch request, level-held until Imem_ack.
REQ-012 The block SHALL have port Imem_addr, output, ADD_WIDTH bits: fetch address, equal to PC_cur.
REQ-013 The block SHALL have port PC_stall, output, 1 bit: drives the PC Stall input.
REQ-014 The block SHALL have port PC_J, output, 1 bit: drives the PC J input.
REQ-015 The block SHALL have port PC_J_add, output, ADD_WIDTH bits: drives the PC jump-address input.
REQ-016 The block SHALL have port If_valid, output, 1 bit: fetch buffer holds an instruction for decode.
REQ-017 The block SHALL have port If_instr, output, 32 bits: buffered instruction.
REQ-018 The block SHALL have port If_pc, output, ADD_WIDTH bits: address of the buffered instruction.
REQ-019 The block SHALL have port Flush_id, output, 1 bit: one-cycle pulse telling decode to discard its contents.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH and HOLD; Imem_req=1 exactly in FETCH.
REQ-021 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-022 In FETCH with Imem_ack=1, no Redirect and no pending redirect, the block SHALL capture Imem_rdata into If_instr and PC_cur into If_pc, set If_valid, pulse PC_stall=0 with PC_J=0 (PC+4), and go to HOLD.
REQ-023 Consume SHALL be defined as If_valid & Id_ready & ~Hz_stall; on consume If_valid SHALL clear next cycle.
REQ-024 In HOLD, consume SHALL move the FSM to FETCH; otherwise it SHALL stay in HOLD with If_instr/If_pc stable. Peak throughput is one instruction per 2 cycles.
REQ-025 PC_stall SHALL be 1 in every cycle except the advance cycle of REQ-022 and redirect-apply cycles.
REQ-026 Redirect apply SHALL mean PC_stall=0, PC_J=1, PC_J_add=target, If_valid cleared next cycle, Flush_id=1 next cycle, next state FETCH.
REQ-027 Redirect in IDLE or HOLD SHALL apply immediately with target Redirect_add, discarding any buffered instruction.
REQ-028 Redirect in FETCH without Imem_ack SHALL latch Redirect_add into a pending register; PC_stall stays 1 and Imem_addr stays unchanged until ack.
REQ-029 A further Redirect while a redirect is pending SHALL overwrite the pending target (newest wins).
REQ-030 On Imem_ack in FETCH with Redirect or pending set, Imem_rdata SHALL be discarded and the redirect applied; target is Redirect_add if Redirect=1, else the pending target; pending clears.
REQ-031 Redirect SHALL take priority over consume in the same cycle; the buffered instruction is flushed, not delivered.
REQ-032 PC_J SHALL be 0 and PC_J_add SHALL be 0 whenever no redirect is being applied.

Reset
REQ-033 While Rst=0, state SHALL be IDLE, pending cleared, and If_valid=0, If_instr=0, If_pc=0, Flush_id=0, Imem_req=0, PC_J=0, PC_J_add=0, PC_stall=1.
REQ-034 Reset asserted mid-fetch SHALL abandon the outstanding request without waiting for Imem_ack.

Verification
REQ-035 Release reset, memory acks on first request cycle with 0x00000013 -> FETCH in cycle 1, If_valid=1 with If_instr=0x00000013, If_pc=0 in cycle 2, PC_stall=0 only in cycle 1.
REQ-036 Id_ready=0 for 3 cycles with If_valid=1 -> no Imem_req, If_instr stable; Hz_stall=1 with Id_ready=1 also holds.
REQ-037 Redirect to 16 while request at PC=4 waits 2 cycles for ack -> ack data dropped, PC_J=1, PC_J_add=16 in ack cycle, Flush_id pulses next cycle, next fetch at 16.
REQ-038 Two Redirects (8 then 20) during one outstanding request -> applied target 20.
REQ-039 Redirect to 24 in HOLD coincident with consume -> If_valid=0 next cycle, no delivery, PC_J_add=24.
REQ-040 Rst asserted while Imem_req=1 -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues fetch requests, buffers one instruction
// for decode, steers the PC (advance / stall / jump) and applies branch redirects.
module fetch_ctrl #(
  parameter int unsigned ADD_WIDTH = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [ADD_WIDTH-1:0] PC_cur,
  input  logic                 Imem_ack,
  input  logic [31:0]          Imem_rdata,
  input  logic                 Id_ready,
  input  logic                 Hz_stall,
  input  logic                 Redirect,
  input  logic [ADD_WIDTH-1:0] Redirect_add,
  output logic                 Imem_req,
  output logic [ADD_WIDTH-1:0] Imem_addr,
  output logic                 PC_stall,
  output logic                 PC_J,
  output logic [ADD_WIDTH-1:0] PC_J_add,
  output logic                 If_valid,
  output logic [31:0]          If_instr,
  output logic [ADD_WIDTH-1:0] If_pc,
  output logic                 Flush_id
);

  localparam int unsigned INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state;
  logic                   pend_valid;
  logic [ADD_WIDTH-1:0]   pend_add;

  logic                   consume;
  logic                   advance;
  logic                   apply;
  logic [ADD_WIDTH-1:0]   apply_add;

  // Per-cycle decisions: advance the PC, apply a redirect, or hold.
  // Gated by reset so the PC-control outputs show reset values asynchronously.
  always_comb begin
    consume   = If_valid & Id_ready & ~Hz_stall;
    advance   = 1'b0;
    apply     = 1'b0;
    apply_add = '0;
    case (state)
      IDLE, HOLD: begin
        if (Redirect) begin
          apply     = 1'b1;
          apply_add = Redirect_add;
        end
      end
      FETCH: begin
        if (Imem_ack) begin
          if (Redirect) begin
            apply     = 1'b1;
            apply_add = Redirect_add;
          end else if (pend_valid) begin
            apply     = 1'b1;
            apply_add = pend_add;
          end else begin
            advance   = 1'b1;
          end
        end
      end
      default: begin
        advance = 1'b0;
      end
    endcase
    if (!Rst) begin
      advance   = 1'b0;
      apply     = 1'b0;
      apply_add = '0;
    end
  end

  // PC steering follows the current-cycle decision; request is a pure state decode.
  assign Imem_req  = (state == FETCH);
  assign Imem_addr = PC_cur;
  assign PC_stall  = ~(advance | apply);
  assign PC_J      = apply;
  assign PC_J_add  = apply_add;

  // FSM, pending-redirect register and fetch buffer.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_add   <= '0;
      If_valid   <= 1'b0;
      If_instr   <= '0;
      If_pc      <= '0;
      Flush_id   <= 1'b0;
    end else begin
      Flush_id <= apply;
      case (state)
        IDLE: begin
          If_valid <= 1'b0;
          state    <= FETCH;
        end
        FETCH: begin
          if (apply) begin
            // Returned word belongs to the wrong path; drop it and refetch.
            pend_valid <= 1'b0;
            pend_add   <= '0;
            If_valid   <= 1'b0;
            state      <= FETCH;
          end else if (advance) begin
            If_instr <= INSTR_WIDTH'(Imem_rdata);
            If_pc    <= PC_cur;
            If_valid <= 1'b1;
            state    <= HOLD;
          end else if (Redirect) begin
            // Request still outstanding: remember newest target until ack.
            pend_valid <= 1'b1;
            pend_add   <= Redirect_add;
          end
        end
        HOLD: begin
          // Redirect wins over consume: buffered instruction is flushed.
          if (apply || consume) begin
            If_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a simple PC register model around it.
module tb_fetch_ctrl;

  localparam int unsigned AW = 5;

  logic          Clk;
  logic          Rst;
  logic [AW-1:0] PC_cur;
  logic          Imem_ack;
  logic [31:0]   Imem_rdata;
  logic          Id_ready;
  logic          Hz_stall;
  logic          Redirect;
  logic [AW-1:0] Redirect_add;
  logic          Imem_req;
  logic [AW-1:0] Imem_addr;
  logic          PC_stall;
  logic          PC_J;
  logic [AW-1:0] PC_J_add;
  logic          If_valid;
  logic [31:0]   If_instr;
  logic [AW-1:0] If_pc;
  logic          Flush_id;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.ADD_WIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst), .PC_cur(PC_cur), .Imem_ack(Imem_ack),
    .Imem_rdata(Imem_rdata), .Id_ready(Id_ready), .Hz_stall(Hz_stall),
    .Redirect(Redirect), .Redirect_add(Redirect_add), .Imem_req(Imem_req),
    .Imem_addr(Imem_addr), .PC_stall(PC_stall), .PC_J(PC_J),
    .PC_J_add(PC_J_add), .If_valid(If_valid), .If_instr(If_instr),
    .If_pc(If_pc), .Flush_id(Flush_id)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // PC register driven by the controller's stall/jump outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)          PC_cur <= '0;
    else if (!PC_stall) PC_cur <= PC_J ? PC_J_add : PC_cur + AW'(4);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves the bench at the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b0; Imem_ack = 1'b0; Imem_rdata = '0; Id_ready = 1'b0;
    Hz_stall = 1'b0; Redirect = 1'b0; Redirect_add = '0;

    // Reset state
    step();
    check("rst_req",    32'(Imem_req), 32'd0);
    check("rst_stall",  32'(PC_stall), 32'd1);
    check("rst_valid",  32'(If_valid), 32'd0);
    check("rst_pcj",    32'(PC_J),     32'd0);
    check("rst_flush",  32'(Flush_id), 32'd0);

    // Cycle 0: IDLE
    Rst = 1'b1;
    #1;
    check("idle_stall", 32'(PC_stall), 32'd1);
    check("idle_req",   32'(Imem_req), 32'd0);
    // Cycle 1: FETCH, ack immediately
    step();
    Imem_ack = 1'b1; Imem_rdata = 32'h0000_0013;
    #1;
    check("c1_req",     32'(Imem_req),  32'd1);
    check("c1_addr",    32'(Imem_addr), 32'd0);
    check("c1_stall",   32'(PC_stall),  32'd0);
    check("c1_pcj",     32'(PC_J),      32'd0);
    check("c1_pcjadd",  32'(PC_J_add),  32'd0);
    // Cycle 2: HOLD with buffered instruction
    step();
    Imem_ack = 1'b0; Imem_rdata = 32'hFFFF_FFFF;
    #1;
    check("c2_valid",   32'(If_valid), 32'd1);
    check("c2_instr",   If_instr,      32'h0000_0013);
    check("c2_pc",      32'(If_pc),    32'd0);
    check("c2_stall",   32'(PC_stall), 32'd1);
    check("c2_req",     32'(Imem_req), 32'd0);

    // Decode not ready, then hazard stall: buffer holds
    for (int i = 0; i < 3; i++) begin
      step();
      check("nrdy_req",   32'(Imem_req), 32'd0);
      check("nrdy_instr", If_instr,      32'h0000_0013);
      check("nrdy_valid", 32'(If_valid), 32'd1);
    end
    Id_ready = 1'b1; Hz_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("hz_req",   32'(Imem_req), 32'd0);
      check("hz_valid", 32'(If_valid), 32'd1);
    end
    Hz_stall = 1'b0;
    #1;
    check("cons_stall", 32'(PC_stall), 32'd1);
    step();
    Id_ready = 1'b0;
    #1;
    check("cons_valid", 32'(If_valid),  32'd0);
    check("cons_req",   32'(Imem_req),  32'd1);
    check("cons_addr",  32'(Imem_addr), 32'd4);

    // Redirect to 16 while fetch at 4 is outstanding for two cycles
    Redirect = 1'b1; Redirect_add = AW'(16);
    #1;
    check("pend_stall", 32'(PC_stall), 32'd1);
    check("pend_pcj",   32'(PC_J),     32'd0);
    step();
    Redirect = 1'b0; Redirect_add = '0;
    #1;
    check("pend_addr",  32'(Imem_addr), 32'd4);
    check("pend_req",   32'(Imem_req),  32'd1);
    step();
    Imem_ack = 1'b1; Imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("r16_pcj",    32'(PC_J),     32'd1);
    check("r16_add",    32'(PC_J_add), 32'd16);
    check("r16_stall",  32'(PC_stall), 32'd0);
    step();
    Imem_ack = 1'b0;
    #1;
    check("r16_flush",  32'(Flush_id),  32'd1);
    check("r16_valid",  32'(If_valid),  32'd0);
    check("r16_addr",   32'(Imem_addr), 32'd16);
    check("r16_pcjadd0",32'(PC_J_add),  32'd0);

    // Two redirects during one request: newest (20) wins
    step();
    check("flush_pulse", 32'(Flush_id), 32'd0);
    Redirect = 1'b1; Redirect_add = AW'(8);
    step();
    Redirect_add = AW'(20);
    step();
    Redirect = 1'b0; Redirect_add = '0; Imem_ack = 1'b1;
    #1;
    check("r20_pcj", 32'(PC_J),     32'd1);
    check("r20_add", 32'(PC_J_add), 32'd20);
    step();
    Imem_ack = 1'b0;
    #1;
    check("r20_addr",  32'(Imem_addr), 32'd20);
    check("r20_flush", 32'(Flush_id),  32'd1);

    // Fetch at 20, then redirect to 24 coincident with consume
    Imem_ack = 1'b1; Imem_rdata = 32'h00A0_0093;
    #1;
    check("f20_stall", 32'(PC_stall), 32'd0);
    step();
    Imem_ack = 1'b0;
    #1;
    check("f20_valid", 32'(If_valid), 32'd1);
    check("f20_pc",    32'(If_pc),    32'd20);
    check("f20_instr", If_instr,      32'h00A0_0093);
    Id_ready = 1'b1; Redirect = 1'b1; Redirect_add = AW'(24);
    #1;
    check("r24_pcj", 32'(PC_J),     32'd1);
    check("r24_add", 32'(PC_J_add), 32'd24);
    step();
    Id_ready = 1'b0; Redirect = 1'b0; Redirect_add = '0;
    #1;
    check("r24_valid", 32'(If_valid),  32'd0);
    check("r24_flush", 32'(Flush_id),  32'd1);
    check("r24_addr",  32'(Imem_addr), 32'd24);

    // Reset mid-fetch with a pending redirect
    Redirect = 1'b1; Redirect_add = AW'(12);
    step();
    Redirect = 1'b0;
    #1;
    check("pre_rst_req", 32'(Imem_req), 32'd1);
    Imem_ack = 1'b1; Redirect = 1'b1; Rst = 1'b0;
    #1;
    check("arst_req",   32'(Imem_req), 32'd0);
    check("arst_stall", 32'(PC_stall), 32'd1);
    check("arst_pcj",   32'(PC_J),     32'd0);
    check("arst_pcjadd",32'(PC_J_add), 32'd0);
    check("arst_valid", 32'(If_valid), 32'd0);
    check("arst_flush", 32'(Flush_id), 32'd0);
    step();
    Imem_ack = 1'b0; Redirect = 1'b0; Rst = 1'b1;
    step();
    Imem_ack = 1'b1; Imem_rdata = 32'h0000_0033;
    #1;
    check("post_req",   32'(Imem_req), 32'd1);
    check("post_pcj",   32'(PC_J),     32'd0);
    check("post_stall", 32'(PC_stall), 32'd0);
    step();
    Imem_ack = 1'b0;
    #1;
    check("post_instr", If_instr,   32'h0000_0033);
    check("post_pc",    32'(If_pc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
